// File: rtl/idex_hazard_reg_pkg.sv
// Shared ID/EX pipeline definitions: default widths, the $0 register number and the bubble control vector.
// Imported by the hazard register, its load-use detector and the bundle interface.
package idex_hazard_reg_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_AW  = 5;
    localparam int DEF_ALUOP_W = 4;
    localparam int DEF_CNT_W   = 16;

    // Architectural $0: writes are discarded, so a load into it never creates a hazard.
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // A non-valid slot keeps its decoded controls but must never write back.
    function automatic ctrl_t qualify_ctrl(input ctrl_t c);
        ctrl_t q;
        q = c;
        if (!c.valid) begin
            q.reg_write = 1'b0;
        end
        return q;
    endfunction

endpackage

// File: rtl/idex_hazard_reg_if.sv
// Decode-to-execute bundle: decoded instruction fields in, registered EX-stage fields and hazard controls out.
// master = decode/control side, slave = the ID/EX hazard register.
interface idex_hazard_reg_if
    import idex_hazard_reg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int CNT_W   = DEF_CNT_W
) ();

    logic               iStall;
    logic               iFlush;
    logic               iValid_ID;
    logic [REG_AW-1:0]  iRs_ID;
    logic [REG_AW-1:0]  iRt_ID;
    logic [REG_AW-1:0]  iwsel_ID;
    logic               iUseRs_ID;
    logic               iUseRt_ID;
    logic               iRegWrite_ID;
    logic               iMemRead_ID;
    logic               iMemWrite_ID;
    logic               iMemToReg_ID;
    logic               iALUSrc_ID;
    logic [ALUOP_W-1:0] iALUOp_ID;
    logic [DATA_W-1:0]  iRsData_ID;
    logic [DATA_W-1:0]  iRtData_ID;
    logic [DATA_W-1:0]  iImm_ID;
    logic [DATA_W-1:0]  iPC_ID;

    logic               oValid_RegD;
    logic [REG_AW-1:0]  oRs_RegD;
    logic [REG_AW-1:0]  oRt_RegD;
    logic [REG_AW-1:0]  owsel_RegD;
    logic               oRegWrite_RegD;
    logic               oMemRead_RegD;
    logic               oMemWrite_RegD;
    logic               oMemToReg_RegD;
    logic               oALUSrc_RegD;
    logic [ALUOP_W-1:0] oALUOp_RegD;
    logic [DATA_W-1:0]  oRsData_RegD;
    logic [DATA_W-1:0]  oRtData_RegD;
    logic [DATA_W-1:0]  oImm_RegD;
    logic [DATA_W-1:0]  oPC_RegD;
    logic               oHold_IFID;
    logic [CNT_W-1:0]   oBubbleCnt;

    modport master (
        output iStall, iFlush, iValid_ID, iRs_ID, iRt_ID, iwsel_ID, iUseRs_ID, iUseRt_ID,
               iRegWrite_ID, iMemRead_ID, iMemWrite_ID, iMemToReg_ID, iALUSrc_ID, iALUOp_ID,
               iRsData_ID, iRtData_ID, iImm_ID, iPC_ID,
        input  oValid_RegD, oRs_RegD, oRt_RegD, owsel_RegD, oRegWrite_RegD, oMemRead_RegD,
               oMemWrite_RegD, oMemToReg_RegD, oALUSrc_RegD, oALUOp_RegD, oRsData_RegD,
               oRtData_RegD, oImm_RegD, oPC_RegD, oHold_IFID, oBubbleCnt
    );

    modport slave (
        input  iStall, iFlush, iValid_ID, iRs_ID, iRt_ID, iwsel_ID, iUseRs_ID, iUseRt_ID,
               iRegWrite_ID, iMemRead_ID, iMemWrite_ID, iMemToReg_ID, iALUSrc_ID, iALUOp_ID,
               iRsData_ID, iRtData_ID, iImm_ID, iPC_ID,
        output oValid_RegD, oRs_RegD, oRt_RegD, owsel_RegD, oRegWrite_RegD, oMemRead_RegD,
               oMemWrite_RegD, oMemToReg_RegD, oALUSrc_RegD, oALUOp_RegD, oRsData_RegD,
               oRtData_RegD, oImm_RegD, oPC_RegD, oHold_IFID, oBubbleCnt
    );

endinterface

// File: rtl/idex_hazard_reg_loaduse_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by the instruction in ID.
// Purely combinational; hold is suppressed by a flush (the dependent instruction dies anyway).
module loaduse_detect
    import idex_hazard_reg_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_wsel,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              stall,
    input  logic              flush,
    output logic              lu,
    output logic              hold
);

    logic ex_is_load;
    logic rs_hit;
    logic rt_hit;

    assign ex_is_load = ex_valid & ex_mem_read & (ex_wsel != REG_AW'(REG_ZERO));
    assign rs_hit     = id_use_rs & (id_rs == ex_wsel);
    assign rt_hit     = id_use_rt & (id_rt == ex_wsel);

    assign lu   = ex_is_load & id_valid & (rs_hit | rt_hit);
    assign hold = stall | (lu & ~flush);

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and global stall freeze.
// Priority per edge: stall (freeze) > flush (bubble) > load-use (bubble, count) > capture.
module idex_hazard_reg
    import idex_hazard_reg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    idex_hazard_reg_if.slave  bus
);

    typedef struct packed {
        ctrl_t              ctrl;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  wsel;
        logic [ALUOP_W-1:0] alu_op;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic [DATA_W-1:0]  pc;
    } stage_t;

    stage_t           stage_q;
    stage_t           stage_d;
    stage_t           stage_cap;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lu;
    logic             hold;

    loaduse_detect #(
        .REG_AW(REG_AW)
    ) u_loaduse_detect (
        .ex_valid    (stage_q.ctrl.valid),
        .ex_mem_read (stage_q.ctrl.mem_read),
        .ex_wsel     (stage_q.wsel),
        .id_valid    (bus.iValid_ID),
        .id_rs       (bus.iRs_ID),
        .id_rt       (bus.iRt_ID),
        .id_use_rs   (bus.iUseRs_ID),
        .id_use_rt   (bus.iUseRt_ID),
        .stall       (bus.iStall),
        .flush       (bus.iFlush),
        .lu          (lu),
        .hold        (hold)
    );

    // Normal capture; a non-valid slot gets a zero destination so forwarding never matches it.
    always_comb begin
        stage_cap                 = '0;
        stage_cap.ctrl.valid      = bus.iValid_ID;
        stage_cap.ctrl.reg_write  = bus.iRegWrite_ID;
        stage_cap.ctrl.mem_read   = bus.iMemRead_ID;
        stage_cap.ctrl.mem_write  = bus.iMemWrite_ID;
        stage_cap.ctrl.mem_to_reg = bus.iMemToReg_ID;
        stage_cap.ctrl.alu_src    = bus.iALUSrc_ID;
        stage_cap.ctrl            = qualify_ctrl(stage_cap.ctrl);
        stage_cap.rs              = bus.iRs_ID;
        stage_cap.rt              = bus.iRt_ID;
        stage_cap.wsel            = bus.iValid_ID ? bus.iwsel_ID : REG_AW'(REG_ZERO);
        stage_cap.alu_op          = bus.iALUOp_ID;
        stage_cap.rs_data         = bus.iRsData_ID;
        stage_cap.rt_data         = bus.iRtData_ID;
        stage_cap.imm             = bus.iImm_ID;
        stage_cap.pc              = bus.iPC_ID;
    end

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (!bus.iStall) begin
            if (bus.iFlush || lu) begin
                stage_d      = '0;
                stage_d.ctrl = CTRL_BUBBLE;
            end else begin
                stage_d = stage_cap;
            end
            // Flush wins over load-use: the killed bubble is not a load-use stall.
            if (!bus.iFlush && lu && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.oValid_RegD    = stage_q.ctrl.valid;
    assign bus.oRegWrite_RegD = stage_q.ctrl.reg_write;
    assign bus.oMemRead_RegD  = stage_q.ctrl.mem_read;
    assign bus.oMemWrite_RegD = stage_q.ctrl.mem_write;
    assign bus.oMemToReg_RegD = stage_q.ctrl.mem_to_reg;
    assign bus.oALUSrc_RegD   = stage_q.ctrl.alu_src;
    assign bus.oRs_RegD       = stage_q.rs;
    assign bus.oRt_RegD       = stage_q.rt;
    assign bus.owsel_RegD     = stage_q.wsel;
    assign bus.oALUOp_RegD    = stage_q.alu_op;
    assign bus.oRsData_RegD   = stage_q.rs_data;
    assign bus.oRtData_RegD   = stage_q.rt_data;
    assign bus.oImm_RegD      = stage_q.imm;
    assign bus.oPC_RegD       = stage_q.pc;
    assign bus.oHold_IFID     = hold;
    assign bus.oBubbleCnt     = cnt_q;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed bench for idex_hazard_reg with a 2-bit bubble counter so saturation is reachable.
// Expected EX-stage state is pushed to a scoreboard at drive time and popped after each edge.
module tb_idex_hazard_reg;
    import idex_hazard_reg_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_REG_AW;
    localparam int OW = DEF_ALUOP_W;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    idex_hazard_reg_if #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) bus ();

    idex_hazard_reg #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs, rt, wsel;
        logic          use_rs, use_rt, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
        logic [OW-1:0] alu_op;
        logic [DW-1:0] rs_data, rt_data, imm, pc;
    } in_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs, rt, wsel;
        logic          reg_write, mem_read, mem_write, mem_to_reg, alu_src;
        logic [OW-1:0] alu_op;
        logic [DW-1:0] rs_data, rt_data, imm, pc;
        logic [CW-1:0] cnt;
    } out_t;

    out_t model;
    out_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input out_t obs, input out_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic out_t observe();
        out_t o;
        o.valid = bus.oValid_RegD;        o.rs = bus.oRs_RegD;
        o.rt = bus.oRt_RegD;              o.wsel = bus.owsel_RegD;
        o.reg_write = bus.oRegWrite_RegD; o.mem_read = bus.oMemRead_RegD;
        o.mem_write = bus.oMemWrite_RegD; o.mem_to_reg = bus.oMemToReg_RegD;
        o.alu_src = bus.oALUSrc_RegD;     o.alu_op = bus.oALUOp_RegD;
        o.rs_data = bus.oRsData_RegD;     o.rt_data = bus.oRtData_RegD;
        o.imm = bus.oImm_RegD;            o.pc = bus.oPC_RegD;
        o.cnt = bus.oBubbleCnt;
        return o;
    endfunction

    task automatic apply(input in_t c, input logic stall, input logic flush);
        bus.iStall = stall;             bus.iFlush = flush;
        bus.iValid_ID = c.valid;        bus.iRs_ID = c.rs;
        bus.iRt_ID = c.rt;              bus.iwsel_ID = c.wsel;
        bus.iUseRs_ID = c.use_rs;       bus.iUseRt_ID = c.use_rt;
        bus.iRegWrite_ID = c.reg_write; bus.iMemRead_ID = c.mem_read;
        bus.iMemWrite_ID = c.mem_write; bus.iMemToReg_ID = c.mem_to_reg;
        bus.iALUSrc_ID = c.alu_src;     bus.iALUOp_ID = c.alu_op;
        bus.iRsData_ID = c.rs_data;     bus.iRtData_ID = c.rt_data;
        bus.iImm_ID = c.imm;            bus.iPC_ID = c.pc;
    endtask

    function automatic in_t mk_lw(input int wsel, input int base, input logic [DW-1:0] pc);
        in_t r = '0;
        r.valid = 1'b1; r.rs = AW'(base); r.wsel = AW'(wsel); r.use_rs = 1'b1;
        r.reg_write = 1'b1; r.mem_read = 1'b1; r.mem_to_reg = 1'b1; r.alu_src = 1'b1;
        r.alu_op = OW'(2); r.rs_data = DW'($urandom); r.imm = DW'(16); r.pc = pc;
        return r;
    endfunction

    function automatic in_t mk_alu(input int wsel, input int rs, input int rt, input logic [DW-1:0] pc);
        in_t r = '0;
        r.valid = 1'b1; r.rs = AW'(rs); r.rt = AW'(rt); r.wsel = AW'(wsel);
        r.use_rs = 1'b1; r.use_rt = 1'b1; r.reg_write = 1'b1; r.alu_op = OW'(5);
        r.rs_data = DW'($urandom); r.rt_data = DW'($urandom); r.pc = pc;
        return r;
    endfunction

    function automatic in_t mk_sw(input int rs, input int rt, input logic use_rt, input logic [DW-1:0] pc);
        in_t r = '0;
        r.valid = 1'b1; r.rs = AW'(rs); r.rt = AW'(rt); r.use_rs = 1'b1; r.use_rt = use_rt;
        r.mem_write = 1'b1; r.alu_src = 1'b1; r.alu_op = OW'(2);
        r.rs_data = DW'($urandom); r.rt_data = DW'($urandom); r.imm = DW'(8); r.pc = pc;
        return r;
    endfunction

    function automatic logic model_lu(input in_t c);
        logic hit;
        hit = (c.use_rs && c.rs == model.wsel) || (c.use_rt && c.rt == model.wsel);
        return model.valid && model.mem_read && (model.wsel != '0) && c.valid && hit;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input string tag, input in_t c, input logic stall, input logic flush);
        out_t nxt;
        out_t exp;
        logic lu;
        apply(c, stall, flush);
        #1;
        lu = model_lu(c);
        check_bit({tag, "/hold"}, bus.oHold_IFID, stall | (lu & ~flush));
        nxt = model;
        if (!stall) begin
            if (flush || lu) begin
                nxt     = '0;
                nxt.cnt = model.cnt;
                if (!flush && model.cnt != '1) nxt.cnt = model.cnt + 1'b1;
            end else begin
                nxt.valid = c.valid; nxt.rs = c.rs; nxt.rt = c.rt;
                nxt.wsel = c.valid ? c.wsel : '0;
                nxt.reg_write = c.valid & c.reg_write;
                nxt.mem_read = c.mem_read; nxt.mem_write = c.mem_write;
                nxt.mem_to_reg = c.mem_to_reg; nxt.alu_src = c.alu_src;
                nxt.alu_op = c.alu_op; nxt.rs_data = c.rs_data; nxt.rt_data = c.rt_data;
                nxt.imm = c.imm; nxt.pc = c.pc;
            end
        end
        sb.push_back(nxt);
        model = nxt;
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check_out(tag, observe(), exp);
        @(negedge clk);
    endtask

    initial begin
        in_t              cur;
        in_t              dep;
        logic [191:0]     rnd;
        logic [DW-1:0]    pc;

        // Reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            cur = rnd[$bits(in_t)-1:0];
            apply(cur, 1'(rnd[191]), 1'(rnd[190]));
            @(posedge clk);
            #1;
            check_out("reset_hold", observe(), '0);
            @(negedge clk);
        end
        apply('0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check_out("reset_release", observe(), '0);
        check_bit("reset_hold_ifid", bus.oHold_IFID, 1'b0);
        @(negedge clk);
        model = '0;
        pc    = DW'(32'h100);

        // lw $8 ; add $9,$8,$1 -> one bubble
        step("lw8", mk_lw(8, 2, pc), 1'b0, 1'b0);           pc += DW'(4);
        dep = mk_alu(9, 8, 1, pc);
        step("lu_bubble", dep, 1'b0, 1'b0);
        step("lu_capture", dep, 1'b0, 1'b0);                 pc += DW'(4);

        // lw $0 never stalls
        step("lw0", mk_lw(0, 3, pc), 1'b0, 1'b0);           pc += DW'(4);
        step("read0", mk_alu(10, 0, 0, pc), 1'b0, 1'b0);     pc += DW'(4);

        // Load-use with concurrent flush
        step("lw8_f", mk_lw(8, 2, pc), 1'b0, 1'b0);         pc += DW'(4);
        dep = mk_alu(12, 8, 4, pc);
        step("lu_flush", dep, 1'b0, 1'b1);
        step("post_flush", dep, 1'b0, 1'b0);                 pc += DW'(4);

        // Stall during load-use, including stall+flush together
        step("lw8_s", mk_lw(8, 5, pc), 1'b0, 1'b0);         pc += DW'(4);
        dep = mk_alu(13, 1, 8, pc);
        step("stall0", dep, 1'b1, 1'b0);
        step("stall1", dep, 1'b1, 1'b1);
        step("stall2", dep, 1'b1, 1'b0);
        step("stall_rel", dep, 1'b0, 1'b0);
        step("stall_cap", dep, 1'b0, 1'b0);                  pc += DW'(4);

        // Store after load: rt dependency only when decode flags rt use
        step("lw8_sw", mk_lw(8, 2, pc), 1'b0, 1'b0);        pc += DW'(4);
        dep = mk_sw(2, 8, 1'b1, pc);
        step("sw_use_rt", dep, 1'b0, 1'b0);
        step("sw_cap", dep, 1'b0, 1'b0);                     pc += DW'(4);
        step("lw8_sw2", mk_lw(8, 2, pc), 1'b0, 1'b0);       pc += DW'(4);
        step("sw_no_rt", mk_sw(2, 8, 1'b0, pc), 1'b0, 1'b0); pc += DW'(4);

        // Non-valid capture: controls kept, destination and write-back cleared
        cur = mk_lw(7, 1, pc);
        cur.valid = 1'b0;
        step("inv_cap", cur, 1'b0, 1'b0);                    pc += DW'(4);
        step("after_inv", mk_alu(11, 7, 7, pc), 1'b0, 1'b0); pc += DW'(4);
        step("lw9", mk_lw(9, 2, pc), 1'b0, 1'b0);           pc += DW'(4);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", observe(), '0);
        check_bit("async_reset_hold", bus.oHold_IFID, 1'b0);
        model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_cap", mk_alu(9, 9, 9, pc), 1'b0, 1'b0); pc += DW'(4);

        // Five back-to-back load-use pairs: counter 1,2,3,3,3
        for (int k = 0; k < 5; k++) begin
            step($sformatf("sat_lw%0d", k), mk_lw(8, 2, pc), 1'b0, 1'b0); pc += DW'(4);
            dep = mk_alu(9, 8, 3, pc);
            step($sformatf("sat_bub%0d", k), dep, 1'b0, 1'b0);
            check_bit($sformatf("sat_cnt%0d", k), (bus.oBubbleCnt == CW'((k < 3) ? k + 1 : 3)), 1'b1);
            step($sformatf("sat_cap%0d", k), dep, 1'b0, 1'b0); pc += DW'(4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idex_hazard_reg.md
Name: idex_hazard_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Sits between the decode stage and execute.
- Its registered outputs (*_RegD) drive the forwarding unit's rs/rt compare inputs and the EX datapath.
- Inserts bubbles for load-use hazards and branch flushes, holds on global stalls, and counts load-use bubbles for performance reporting.

Parameters:
- DATA_W, 32, width of register-file data, immediate and PC.
- REG_AW, 5, register-address width.
- ALUOP_W, 4, ALU operation code width.
- CNT_W, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- iStall  in  1  global stall (e.g. D-cache miss); freeze whole register
- iFlush  in  1  branch/jump taken; kill the instruction entering EX
- iValid_ID  in  1  decode slot holds a real instruction
- iRs_ID, iRt_ID, iwsel_ID  in  REG_AW each  source and destination register numbers
- iUseRs_ID, iUseRt_ID  in  1 each  instruction actually reads rs / rt
- iRegWrite_ID, iMemRead_ID, iMemWrite_ID, iMemToReg_ID, iALUSrc_ID  in  1 each  control bits
- iALUOp_ID  in  ALUOP_W  ALU operation
- iRsData_ID, iRtData_ID, iImm_ID, iPC_ID  in  DATA_W each  operands, sign-extended immediate, PC+4
- oValid_RegD  out  1  registered valid
- oRs_RegD, oRt_RegD, owsel_RegD  out  REG_AW each  registered register numbers (to forwarding unit)
- oRegWrite_RegD, oMemRead_RegD, oMemWrite_RegD, oMemToReg_RegD, oALUSrc_RegD  out  1 each  registered control
- oALUOp_RegD  out  ALUOP_W  registered ALU op
- oRsData_RegD, oRtData_RegD, oImm_RegD, oPC_RegD  out  DATA_W each  registered data
- oHold_IFID  out  1  combinational; hold PC and IF/ID this cycle
- oBubbleCnt  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst_n low, async): every registered output is 0, oBubbleCnt = 0. The stage is then a bubble.
- Load-use detect (combinational), lu =
  - oValid_RegD & oMemRead_RegD & (owsel_RegD != 0) & iValid_ID
  - & ((iUseRs_ID & iRs_ID == owsel_RegD) | (iUseRt_ID & iRt_ID == owsel_RegD))
- oHold_IFID = iStall | (lu & ~iFlush).
- Per-edge update, in priority order:
  1. iStall=1: all registers keep their value, counter unchanged (overrides flush and lu).
  2. iFlush=1: load a bubble, counter unchanged.
  3. lu=1: load a bubble; oBubbleCnt += 1, saturating at all-ones.
  4. Otherwise: capture all *_ID inputs; oValid_RegD = iValid_ID.
- Bubble definition:
  - oValid, oRegWrite, oMemRead, oMemWrite, oMemToReg are 0; owsel = 0.
  - Remaining fields are don't-care; the implementation clears them to 0 for determinism.
- iValid_ID=0 on a normal capture: control bits are still captured. Downstream qualifies on oValid_RegD. owsel/RegWrite are forced to 0 so forwarding never matches.
- Load-use latency: exactly one bubble per dependent load. After the bubble, the load is in MEM and the forwarding unit covers the dependency. No internal state beyond the pipeline register and counter.
- Load writing $0 never stalls.
- Store after load: the rt dependency stalls only if iUseRt_ID is asserted by decode.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). The first edge after deassertion behaves as a normal capture.

Decomposition:
- Shared pipeline package holds:
  - the bubble-control constant (all-zero control vector);
  - REG_AW/DATA_W/ALUOP_W defaults;
  - the $0 register constant.
- One natural sub-module: loaduse_detect (the purely combinational lu/hold logic), instantiated once. Register, priority and counter logic stay in the top.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release -> all outputs 0, oHold_IFID=0, oBubbleCnt=0.
- lw $8 then add $9,$8,$1 (rs=8, UseRs=1) -> cycle after lw captured: oHold_IFID=1; next edge loads a bubble (oValid_RegD=0, oRegWrite_RegD=0); the add is captured on the following edge; oBubbleCnt=1.
- lw $0 followed by an instruction reading $0 -> oHold_IFID=0, no bubble, counter stays 0.
- lw $8 then add with rs=8 and iFlush=1 in the same cycle -> bubble loaded, oHold_IFID=0, oBubbleCnt unchanged.
- iStall=1 for 3 cycles during load-use -> registers frozen and oHold_IFID=1 throughout; after release, exactly one bubble and counter +1.
- CNT_W=2, five back-to-back load-use pairs -> oBubbleCnt reads 1,2,3,3,3.
